// File: rtl/gpio_cfg_serializer_if.sv
// Bundle of the request, config-fetch and serial-chain signals for gpio_cfg_serializer.
// master: the housekeeping side (drives xfer_start, returns config words, optional bit-bang pins).
// slave : the serializer engine (drives busy/done, fetch indices and the serial_* pins).
// Optional macro GPIO_CFG_BITBANG_EN adds the bb_* bit-bang override signals.
interface gpio_cfg_serializer_if #(
   parameter int unsigned CFG_W = 13
);
   logic             xfer_start;
   logic             xfer_busy;
   logic             xfer_done;
   logic [5:0]       cfg_rd_idx_1;
   logic [5:0]       cfg_rd_idx_2;
   logic [CFG_W-1:0] cfg_rd_data_1;
   logic [CFG_W-1:0] cfg_rd_data_2;
   logic             serial_clock;
   logic             serial_load;
   logic             serial_resetn;
   logic             serial_data_1;
   logic             serial_data_2;
`ifdef GPIO_CFG_BITBANG_EN
   logic             bb_enable;
   logic             bb_clock;
   logic             bb_load;
   logic             bb_resetn;
   logic             bb_data_1;
   logic             bb_data_2;

   modport master (
      output xfer_start, cfg_rd_data_1, cfg_rd_data_2,
      output bb_enable, bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2,
      input  xfer_busy, xfer_done, cfg_rd_idx_1, cfg_rd_idx_2,
      input  serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2
   );
   modport slave (
      input  xfer_start, cfg_rd_data_1, cfg_rd_data_2,
      input  bb_enable, bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2,
      output xfer_busy, xfer_done, cfg_rd_idx_1, cfg_rd_idx_2,
      output serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2
   );
`else
   modport master (
      output xfer_start, cfg_rd_data_1, cfg_rd_data_2,
      input  xfer_busy, xfer_done, cfg_rd_idx_1, cfg_rd_idx_2,
      input  serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2
   );
   modport slave (
      input  xfer_start, cfg_rd_data_1, cfg_rd_data_2,
      output xfer_busy, xfer_done, cfg_rd_idx_1, cfg_rd_idx_2,
      output serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2
   );
`endif
endinterface

// File: rtl/gpio_cfg_serializer.sv
// Serial-load engine for the two user GPIO control chains.
// Fetches one config word per chain per pad (farthest pad first), shifts both words
// MSB first on serial_data_1/2 with a divided serial_clock, then pulses serial_load.
// Ports:
//   wb_clk_i, wb_rst_i : system clock, synchronous active-high reset
//   bus (slave)        : xfer_start/busy/done, cfg_rd_idx_*/cfg_rd_data_*, serial_* pins
// Optional macro GPIO_CFG_BITBANG_EN: bb_* inputs override the serial_* pins (registered)
// and abort any transfer in progress.
module gpio_cfg_serializer #(
   parameter int unsigned PADS  = 19,
   parameter int unsigned CFG_W = 13,
   parameter int unsigned DIV   = 4
) (
   input logic                wb_clk_i,
   input logic                wb_rst_i,
   gpio_cfg_serializer_if.slave bus
);
   localparam int unsigned KW = $clog2(PADS + 1);
   localparam int unsigned BW = $clog2(CFG_W + 1);
   localparam int unsigned CW = $clog2(DIV + 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, LATCH, SHIFT_LO, SHIFT_HI, LOAD_HI, LOAD_LO
   } state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic [BW-1:0]    b_q;
   logic [CW-1:0]    cnt_q;
   logic [CFG_W-1:0] sh1_q;
   logic [CFG_W-1:0] sh2_q;
   logic             busy_q;
   logic             done_q;
   logic [5:0]       idx1_q;
   logic [5:0]       idx2_q;
   logic             sclk_q;
   logic             sload_q;
   logic             sresetn_q;
   logic             sd1_q;
   logic             sd2_q;
   logic             cnt_last_c;

   // Last cycle of a DIV-long timed state
   assign cnt_last_c = (cnt_q == CW'(DIV - 1));

   assign bus.xfer_busy     = busy_q;
   assign bus.xfer_done     = done_q;
   assign bus.cfg_rd_idx_1  = idx1_q;
   assign bus.cfg_rd_idx_2  = idx2_q;
   assign bus.serial_clock  = sclk_q;
   assign bus.serial_load   = sload_q;
   assign bus.serial_resetn = sresetn_q;
   assign bus.serial_data_1 = sd1_q;
   assign bus.serial_data_2 = sd2_q;

   // Engine FSM; every output is set on entry to the state that owns it
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         k_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         sh1_q     <= '0;
         sh2_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         idx1_q    <= '0;
         idx2_q    <= '0;
         sclk_q    <= 1'b0;
         sload_q   <= 1'b0;
         sresetn_q <= 1'b0;
         sd1_q     <= 1'b0;
         sd2_q     <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         sresetn_q <= 1'b1;
`ifdef GPIO_CFG_BITBANG_EN
         if (bus.bb_enable) begin
            // Bit-bang owns the pins; drop any transfer silently
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            sclk_q    <= bus.bb_clock;
            sload_q   <= bus.bb_load;
            sresetn_q <= bus.bb_resetn;
            sd1_q     <= bus.bb_data_1;
            sd2_q     <= bus.bb_data_2;
         end else
`endif
         begin
            case (state_q)
               IDLE: begin
                  sclk_q  <= 1'b0;
                  sload_q <= 1'b0;
                  sd1_q   <= 1'b0;
                  sd2_q   <= 1'b0;
                  if (bus.xfer_start) begin
                     busy_q  <= 1'b1;
                     k_q     <= '0;
                     idx1_q  <= 6'(PADS - 32'd1);
                     idx2_q  <= 6'(PADS);
                     state_q <= FETCH;
                  end
               end
               FETCH: state_q <= LATCH;
               LATCH: begin
                  // Present the MSB now, keep the rest left-aligned for later bits
                  sd1_q   <= bus.cfg_rd_data_1[CFG_W-1];
                  sd2_q   <= bus.cfg_rd_data_2[CFG_W-1];
                  sh1_q   <= bus.cfg_rd_data_1 << 1;
                  sh2_q   <= bus.cfg_rd_data_2 << 1;
                  b_q     <= BW'(CFG_W - 1);
                  cnt_q   <= '0;
                  sclk_q  <= 1'b0;
                  state_q <= SHIFT_LO;
               end
               SHIFT_LO: begin
                  if (cnt_last_c) begin
                     cnt_q   <= '0;
                     sclk_q  <= 1'b1;
                     state_q <= SHIFT_HI;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               SHIFT_HI: begin
                  if (cnt_last_c) begin
                     cnt_q  <= '0;
                     sclk_q <= 1'b0;
                     if (b_q != '0) begin
                        b_q     <= b_q - BW'(1);
                        sd1_q   <= sh1_q[CFG_W-1];
                        sd2_q   <= sh2_q[CFG_W-1];
                        sh1_q   <= sh1_q << 1;
                        sh2_q   <= sh2_q << 1;
                        state_q <= SHIFT_LO;
                     end else if (k_q != KW'(PADS - 1)) begin
                        // Next pad: chain 1 walks down, chain 2 walks up
                        k_q     <= k_q + KW'(1);
                        idx1_q  <= 6'(PADS - 32'd2 - 32'(k_q));
                        idx2_q  <= 6'(PADS + 32'd1 + 32'(k_q));
                        state_q <= FETCH;
                     end else begin
                        sd1_q   <= 1'b0;
                        sd2_q   <= 1'b0;
                        sload_q <= 1'b1;
                        state_q <= LOAD_HI;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               LOAD_HI: begin
                  if (cnt_last_c) begin
                     cnt_q   <= '0;
                     sload_q <= 1'b0;
                     state_q <= LOAD_LO;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               LOAD_LO: begin
                  if (cnt_last_c) begin
                     cnt_q   <= '0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Scoreboard bench for gpio_cfg_serializer: main instance (PADS=19, DIV=4) and a
// small instance (PADS=3, DIV=1). Stimulus pushes expected transfer results; monitors
// pop and compare on every xfer_done pulse.
module tb_gpio_cfg_serializer;
   localparam int unsigned CFG_W = 13;

   typedef struct {
      int   lat;
      int   rises;
      int   load_w;
      logic pat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic [CFG_W-1:0] mem [0:63];
   exp_t exp_q[$];
   exp_t exp_s_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gpio_cfg_serializer_if #(.CFG_W(CFG_W)) bus ();
   gpio_cfg_serializer_if #(.CFG_W(CFG_W)) bus_s ();

   gpio_cfg_serializer #(.PADS(19), .CFG_W(CFG_W), .DIV(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));
   gpio_cfg_serializer #(.PADS(3), .CFG_W(CFG_W), .DIV(1)) dut_s (
      .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus_s));

   // Config RAM with one cycle read latency
   always @(posedge clk) begin
      bus.cfg_rd_data_1   <= mem[bus.cfg_rd_idx_1];
      bus.cfg_rd_data_2   <= mem[bus.cfg_rd_idx_2];
      bus_s.cfg_rd_data_1 <= mem[bus_s.cfg_rd_idx_1];
      bus_s.cfg_rd_data_2 <= mem[bus_s.cfg_rd_idx_2];
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int win(input logic [255:0] v, input int base);
      int r = 0;
      for (int j = 0; j < 13; j++) r = (r << 1) | int'(v[base+j]);
      return r;
   endfunction

   function automatic int ones(input logic [255:0] v, input int lo, input int hi);
      int r = 0;
      for (int j = lo; j <= hi; j++) r += int'(v[j]);
      return r;
   endfunction

   // Main monitor
   logic [255:0] c1_bits, c2_bits;
   int   t_start = 0, rises = 0, load_w = 0;
   logic busy_p = 1'b0, sclk_p = 1'b0;
   exp_t e;

   always @(negedge clk) begin
      if (bus.xfer_busy && !busy_p) begin
         t_start = cyc - 1;
         rises   = 0;
         load_w  = 0;
         c1_bits = '0;
         c2_bits = '0;
      end
      if (bus.serial_clock && !sclk_p) begin
         if (rises < 256) begin
            c1_bits[rises] = bus.serial_data_1;
            c2_bits[rises] = bus.serial_data_2;
         end
         rises++;
      end
      if (bus.serial_load) load_w++;
      if (bus.xfer_done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done pulse at cycle %0d, expected none", cyc);
         end else begin
            e = exp_q.pop_front();
            check("done_latency", cyc - t_start, e.lat);
            check("clock_rises", rises, e.rises);
            check("load_width", load_w, e.load_w);
            check("busy_at_done", int'(bus.xfer_busy), 0);
            if (e.pat) begin
               check("chain1_first_gpio18", win(c1_bits, 0), 'h0A5A);
               check("chain2_first_gpio19", win(c2_bits, 0), 'h1234);
               check("chain1_last_gpio0", win(c1_bits, 234), 'h1809);
               check("chain2_last_gpio37", win(c2_bits, 234), 'h1809);
               check("chain1_mid_zero", ones(c1_bits, 13, 233), 0);
               check("chain2_mid_zero", ones(c2_bits, 13, 233), 0);
            end
         end
      end
      busy_p = bus.xfer_busy;
      sclk_p = bus.serial_clock;
   end

   // Small-instance monitor: rises, latency, clock high/low run lengths
   int   s_t = 0, s_rises = 0, s_load = 0, s_hi = 0, s_lo = 0;
   int   s_max_hi = 0, s_min_lo = 1000, s_max_lo = 0;
   logic s_busy_p = 1'b0, s_clk_p = 1'b0;
   exp_t es;

   always @(negedge clk) begin
      if (bus_s.xfer_busy && !s_busy_p) begin
         s_t = cyc - 1; s_rises = 0; s_load = 0; s_hi = 0; s_lo = 0;
         s_max_hi = 0; s_min_lo = 1000; s_max_lo = 0;
      end
      if (bus_s.serial_clock) begin
         if (!s_clk_p) begin
            s_rises++;
            if (s_lo < s_min_lo) s_min_lo = s_lo;
            if (s_lo > s_max_lo) s_max_lo = s_lo;
            s_hi = 0;
         end
         s_hi++;
         if (s_hi > s_max_hi) s_max_hi = s_hi;
      end else begin
         if (s_clk_p) s_lo = 0;
         s_lo++;
      end
      if (bus_s.serial_load) s_load++;
      if (bus_s.xfer_done) begin
         if (exp_s_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL small_unexpected_done: got done pulse at cycle %0d, expected none", cyc);
         end else begin
            es = exp_s_q.pop_front();
            check("small_done_latency", cyc - s_t, es.lat);
            check("small_clock_rises", s_rises, es.rises);
            check("small_load_width", s_load, es.load_w);
            check("small_clock_high_len", s_max_hi, 1);
            check("small_clock_low_min", s_min_lo, 1);
            check("small_clock_low_max", s_max_lo, 3);
         end
      end
      s_busy_p = bus_s.xfer_busy;
      s_clk_p  = bus_s.serial_clock;
   end

   task automatic pulse_start();
      @(negedge clk) bus.xfer_start = 1'b1;
      @(negedge clk) bus.xfer_start = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
         exp_q.delete();
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, int'(bus.xfer_busy), 0);
      check({tag, "_done"}, int'(bus.xfer_done), 0);
      check({tag, "_sclk"}, int'(bus.serial_clock), 0);
      check({tag, "_sload"}, int'(bus.serial_load), 0);
      check({tag, "_sresetn"}, int'(bus.serial_resetn), 0);
      check({tag, "_sdata1"}, int'(bus.serial_data_1), 0);
      check({tag, "_sdata2"}, int'(bus.serial_data_2), 0);
      check({tag, "_idx1"}, int'(bus.cfg_rd_idx_1), 0);
      check({tag, "_idx2"}, int'(bus.cfg_rd_idx_2), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[18] = 13'h0A5A;
      mem[19] = 13'h1234;
      mem[0]  = 13'h1809;
      mem[37] = 13'h1809;
      bus.xfer_start   = 1'b0;
      bus_s.xfer_start = 1'b0;
`ifdef GPIO_CFG_BITBANG_EN
      bus.bb_enable = 1'b0; bus.bb_clock = 1'b0; bus.bb_load = 1'b0;
      bus.bb_resetn = 1'b0; bus.bb_data_1 = 1'b0; bus.bb_data_2 = 1'b0;
      bus_s.bb_enable = 1'b0; bus_s.bb_clock = 1'b0; bus_s.bb_load = 1'b0;
      bus_s.bb_resetn = 1'b0; bus_s.bb_data_1 = 1'b0; bus_s.bb_data_2 = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check("resetn_after_reset", int'(bus.serial_resetn), 1);

      // Full transfer with directed pad pattern
      exp_q.push_back('{lat: 2023, rises: 247, load_w: 4, pat: 1'b1});
      pulse_start();
      wait_empty(2100);
      repeat (3) @(negedge clk);
      check("busy_idle_after_done", int'(bus.xfer_busy), 0);

      // Start pulse mid-transfer must be ignored
      exp_q.push_back('{lat: 2023, rises: 247, load_w: 4, pat: 1'b0});
      pulse_start();
      repeat (498) @(negedge clk);
      pulse_start();
      wait_empty(2100);
      repeat (20) @(negedge clk);
      check("busy_after_ignored_start", int'(bus.xfer_busy), 0);

      // Reset mid-transfer aborts without done, then a clean transfer
      exp_q.push_back('{lat: 2023, rises: 247, load_w: 4, pat: 1'b0});
      pulse_start();
      repeat (998) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("abort");
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      check("resetn_after_abort", int'(bus.serial_resetn), 1);
      repeat (2100) @(negedge clk);
      exp_q.push_back('{lat: 2023, rises: 247, load_w: 4, pat: 1'b1});
      pulse_start();
      wait_empty(2100);

`ifdef GPIO_CFG_BITBANG_EN
      // Bit-bang takeover mid-transfer
      pulse_start();
      repeat (300) @(negedge clk);
      bus.bb_enable = 1'b1; bus.bb_resetn = 1'b1; bus.bb_clock = 1'b1;
      @(negedge clk);
      check("bb_clock_1", int'(bus.serial_clock), 1);
      check("bb_busy_dropped", int'(bus.xfer_busy), 0);
      bus.bb_clock = 1'b0;
      @(negedge clk);
      check("bb_clock_0", int'(bus.serial_clock), 0);
      bus.bb_clock = 1'b1;
      @(negedge clk);
      check("bb_clock_1b", int'(bus.serial_clock), 1);
      bus.bb_enable = 1'b0; bus.bb_clock = 1'b0;
      @(negedge clk);
      check("bb_release_clock", int'(bus.serial_clock), 0);
      check("bb_release_resetn", int'(bus.serial_resetn), 1);
      check("bb_release_busy", int'(bus.xfer_busy), 0);
      repeat (2100) @(negedge clk);
`endif

      // Small instance: PADS=3, DIV=1
      exp_s_q.push_back('{lat: 87, rises: 39, load_w: 1, pat: 1'b0});
      @(negedge clk) bus_s.xfer_start = 1'b1;
      @(negedge clk) bus_s.xfer_start = 1'b0;
      begin
         int n = 0;
         while (exp_s_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (exp_s_q.size() != 0) begin
            failures++;
            $display("FAIL small_done_timeout: got no done within 200 cycles, expected done");
         end
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
